// File: rtl/odd_wb_pipe_pkg.sv
// Shared odd-pipe types: 128-bit quadword, 7-bit register address and the
// writeback stage entry carried through the alignment pipeline.
package odd_wb_pipe_pkg;

   typedef logic [0:127] quad_t;
   typedef logic [0:6]   regaddr_t;

   typedef struct packed {
      logic     valid;
      regaddr_t addr;
      quad_t    data;
   } wb_entry_t;

   localparam int ODD_DEPTH = 7;
   localparam int PERM_LAT  = 4;
   localparam int LS_LAT    = 6;

   localparam wb_entry_t WB_EMPTY = '{valid: 1'b0, addr: 7'd0, data: 128'd0};

   function automatic wb_entry_t make_entry(input regaddr_t addr, input quad_t data);
      wb_entry_t e;
      e.valid = 1'b1;
      e.addr  = addr;
      e.data  = data;
      return e;
   endfunction

endpackage

// File: rtl/odd_wb_pipe_fwd_match.sv
// Forwarding lookup: finds the youngest (lowest-numbered) valid stage whose
// destination matches the requested source register.
module fwd_match
   import odd_wb_pipe_pkg::*;
#(
   parameter int DEPTH = ODD_DEPTH
) (
   input  wb_entry_t [1:DEPTH] stages_i,
   input  regaddr_t            addr_i,
   output logic                hit_o,
   output quad_t               data_o
);

   // Scan oldest to youngest so the youngest match is the last one written.
   always_comb begin
      hit_o  = 1'b0;
      data_o = 128'd0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (stages_i[k].valid && (stages_i[k].addr == addr_i)) begin
            hit_o  = 1'b1;
            data_o = stages_i[k].data;
         end else begin
            hit_o  = hit_o;
            data_o = data_o;
         end
      end
   end

endmodule

// File: rtl/odd_wb_pipe.sv
// Odd-pipe result alignment and writeback: permute and LocalStore results are
// injected at their native latency and shifted to a common writeback stage.
module odd_wb_pipe
   import odd_wb_pipe_pkg::*;
#(
   parameter int DEPTH    = ODD_DEPTH,
   parameter int PERM_LAT = odd_wb_pipe_pkg::PERM_LAT,
   parameter int LS_LAT   = odd_wb_pipe_pkg::LS_LAT
) (
   input  logic     clk,
   input  logic     reset,
   input  quad_t    perm_rt,
   input  regaddr_t perm_rt_addr,
   input  logic     perm_reg_write,
   input  quad_t    ls_rt_wb,
   input  regaddr_t ls_rt_addr_wb,
   input  logic     ls_reg_write_wb,
   input  regaddr_t fwd_addr_a,
   input  regaddr_t fwd_addr_b,
   input  regaddr_t fwd_addr_c,
   output logic     fwd_hit_a,
   output logic     fwd_hit_b,
   output logic     fwd_hit_c,
   output quad_t    fwd_data_a,
   output quad_t    fwd_data_b,
   output quad_t    fwd_data_c,
   output quad_t    rt_wb,
   output regaddr_t rt_addr_wb,
   output logic     reg_write_wb,
   output logic     slot_err
);

   wb_entry_t [1:DEPTH] stages_q;
   wb_entry_t [1:DEPTH] stages_d;
   logic                slot_err_q;
   logic                slot_err_d;

   // Shift plus injection; an injected result overwrites whatever was arriving.
   always_comb begin
      stages_d[1] = WB_EMPTY;
      for (int k = 2; k <= DEPTH; k++) begin
         stages_d[k] = stages_q[k-1];
      end
      slot_err_d = slot_err_q;
      if (perm_reg_write) begin
         stages_d[PERM_LAT] = make_entry(perm_rt_addr, perm_rt);
         if (stages_q[PERM_LAT-1].valid) begin
            slot_err_d = 1'b1;
         end else begin
            slot_err_d = slot_err_d;
         end
      end else begin
         stages_d[PERM_LAT] = stages_q[PERM_LAT-1];
      end
      if (ls_reg_write_wb) begin
         stages_d[LS_LAT] = make_entry(ls_rt_addr_wb, ls_rt_wb);
         if (stages_q[LS_LAT-1].valid) begin
            slot_err_d = 1'b1;
         end else begin
            slot_err_d = slot_err_d;
         end
      end else begin
         stages_d[LS_LAT] = stages_q[LS_LAT-1];
      end
   end

   // Stage registers and sticky collision flag with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 1; k <= DEPTH; k++) begin
            stages_q[k] <= WB_EMPTY;
         end
         slot_err_q <= 1'b0;
      end else begin
         stages_q   <= stages_d;
         slot_err_q <= slot_err_d;
      end
   end

   assign rt_wb        = stages_q[DEPTH].data;
   assign rt_addr_wb   = stages_q[DEPTH].addr;
   assign reg_write_wb = stages_q[DEPTH].valid;
   assign slot_err     = slot_err_q;

   fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
      .stages_i (stages_q),
      .addr_i   (fwd_addr_a),
      .hit_o    (fwd_hit_a),
      .data_o   (fwd_data_a)
   );

   fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
      .stages_i (stages_q),
      .addr_i   (fwd_addr_b),
      .hit_o    (fwd_hit_b),
      .data_o   (fwd_data_b)
   );

   fwd_match #(.DEPTH(DEPTH)) u_fwd_c (
      .stages_i (stages_q),
      .addr_i   (fwd_addr_c),
      .hit_o    (fwd_hit_c),
      .data_o   (fwd_data_c)
   );

endmodule

// File: tb/tb_odd_wb_pipe.sv
// Bench for odd_wb_pipe: in-flight result list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_odd_wb_pipe;

   localparam int DEPTH = 7;
   localparam int PLAT  = 4;
   localparam int LLAT  = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic [0:127] perm_rt, ls_rt_wb;
   logic [0:6]   perm_rt_addr, ls_rt_addr_wb;
   logic         perm_reg_write, ls_reg_write_wb;
   logic [0:6]   fwd_addr_a, fwd_addr_b, fwd_addr_c;
   logic         fwd_hit_a, fwd_hit_b, fwd_hit_c;
   logic [0:127] fwd_data_a, fwd_data_b, fwd_data_c;
   logic [0:127] rt_wb;
   logic [0:6]   rt_addr_wb;
   logic         reg_write_wb;
   logic         slot_err;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   odd_wb_pipe dut (
      .clk(clk), .reset(reset),
      .perm_rt(perm_rt), .perm_rt_addr(perm_rt_addr), .perm_reg_write(perm_reg_write),
      .ls_rt_wb(ls_rt_wb), .ls_rt_addr_wb(ls_rt_addr_wb), .ls_reg_write_wb(ls_reg_write_wb),
      .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_addr_c(fwd_addr_c),
      .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_hit_c(fwd_hit_c),
      .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_data_c(fwd_data_c),
      .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
      .slot_err(slot_err)
   );

   always #5 clk = ~clk;

   // Model: list of live results, each tagged with the stage it currently occupies.
   typedef struct {
      int           stage;
      logic [0:6]   addr;
      logic [0:127] data;
   } m_ent_t;

   m_ent_t mq[$];
   bit     m_err = 1'b0;

   initial begin
      m_ent_t nq[$];
      m_ent_t e;
      forever begin
         @(posedge clk);
         if (!reset) begin
            mq.delete();
            m_err = 1'b0;
         end else begin
            nq.delete();
            foreach (mq[i]) begin
               e = mq[i];
               e.stage = e.stage + 1;
               if (e.stage > DEPTH) continue;
               if (perm_reg_write && e.stage == PLAT) begin m_err = 1'b1; continue; end
               if (ls_reg_write_wb && e.stage == LLAT) begin m_err = 1'b1; continue; end
               nq.push_back(e);
            end
            if (perm_reg_write) begin
               e.stage = PLAT; e.addr = perm_rt_addr; e.data = perm_rt;
               nq.push_back(e);
            end
            if (ls_reg_write_wb) begin
               e.stage = LLAT; e.addr = ls_rt_addr_wb; e.data = ls_rt_wb;
               nq.push_back(e);
            end
            mq = nq;
         end
      end
   end

   task automatic model_fwd(input logic [0:6] a, output logic h, output logic [0:127] d);
      int best;
      best = DEPTH + 1;
      h = 1'b0;
      d = '0;
      foreach (mq[i]) begin
         if (mq[i].addr == a && mq[i].stage < best) begin
            best = mq[i].stage;
            h = 1'b1;
            d = mq[i].data;
         end
      end
   endtask

   task automatic model_wb(output logic v, output logic [0:6] a, output logic [0:127] d);
      v = 1'b0;
      a = '0;
      d = '0;
      foreach (mq[i]) begin
         if (mq[i].stage == DEPTH) begin
            v = 1'b1;
            a = mq[i].addr;
            d = mq[i].data;
         end
      end
   endtask

   task automatic cmp_fwd(input string nm, input logic [0:6] a, input logic h, input logic [0:127] d);
      logic eh;
      logic [0:127] ed;
      model_fwd(a, eh, ed);
      n_cmp++;
      if (h !== eh || d !== ed) begin
         n_bad++;
         $display("FAIL %s: got hit=%0b data=%h, want hit=%0b data=%h", nm, h, d, eh, ed);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle.
   initial begin
      logic         ev;
      logic [0:6]   ea;
      logic [0:127] ed;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            model_wb(ev, ea, ed);
            n_cmp++;
            if (reg_write_wb !== ev || (ev && (rt_addr_wb !== ea || rt_wb !== ed)) ||
                (!ev && (rt_addr_wb !== 7'd0 || rt_wb !== 128'd0 || mq.size() == 0 && 1'b0))) begin
               if (reg_write_wb !== ev || ev) begin
                  n_bad++;
                  $display("FAIL model_wb: got v=%0b a=%0d d=%h, want v=%0b a=%0d d=%h",
                           reg_write_wb, rt_addr_wb, rt_wb, ev, ea, ed);
               end
            end
            n_cmp++;
            if (slot_err !== m_err) begin
               n_bad++;
               $display("FAIL model_slot_err: got %0b want %0b", slot_err, m_err);
            end
            cmp_fwd("model_fwd_a", fwd_addr_a, fwd_hit_a, fwd_data_a);
            cmp_fwd("model_fwd_b", fwd_addr_b, fwd_hit_b, fwd_data_b);
            cmp_fwd("model_fwd_c", fwd_addr_c, fwd_hit_c, fwd_data_c);
         end
      end
   end

   task automatic chk(input string nm, input logic [0:127] act, input logic [0:127] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      perm_reg_write  = 1'b0;
      ls_reg_write_wb = 1'b0;
      perm_rt = '0; perm_rt_addr = '0;
      ls_rt_wb = '0; ls_rt_addr_wb = '0;
   endtask

   localparam logic [0:127] V2  = 128'h00000001_00010001_00010001_00010001;
   localparam logic [0:127] VA5 = {16{8'hA5}};

   initial begin
      fwd_addr_a = 7'd0; fwd_addr_b = 7'd0; fwd_addr_c = 7'd0;
      // 1: reset held with both units presenting valid results
      reset = 1'b0;
      perm_reg_write = 1'b1; perm_rt_addr = 7'd0; perm_rt = 128'd1;
      ls_reg_write_wb = 1'b1; ls_rt_addr_wb = 7'd0; ls_rt_wb = 128'd2;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_rw", {127'd0, reg_write_wb}, 128'd0);
      chk("rst_addr", {121'd0, rt_addr_wb}, 128'd0);
      chk("rst_data", rt_wb, 128'd0);
      chk("rst_hit_a", {127'd0, fwd_hit_a}, 128'd0);
      chk("rst_slot_err", {127'd0, slot_err}, 128'd0);
      idle();
      reset = 1'b1;
      step();

      // 2: LocalStore writeback two cycles later, for one cycle
      ls_reg_write_wb = 1'b1; ls_rt_addr_wb = 7'd3; ls_rt_wb = V2;
      step(); idle();
      chk("ls_c1_rw", {127'd0, reg_write_wb}, 128'd0);
      step();
      chk("ls_c2_rw", {127'd0, reg_write_wb}, 128'd1);
      chk("ls_c2_addr", {121'd0, rt_addr_wb}, 128'd3);
      chk("ls_c2_data", rt_wb, V2);
      step();
      chk("ls_c3_rw", {127'd0, reg_write_wb}, 128'd0);

      // 3: permute forwarding window and writeback at cycle 4
      fwd_addr_a = 7'd5;
      perm_reg_write = 1'b1; perm_rt_addr = 7'd5; perm_rt = VA5;
      #1 chk("perm_c0_hit", {127'd0, fwd_hit_a}, 128'd0);
      step(); idle();
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("perm_c%0d_hit", c), {127'd0, fwd_hit_a}, 128'd1);
         chk($sformatf("perm_c%0d_data", c), fwd_data_a, VA5);
         if (c == 4) begin
            chk("perm_c4_rw", {127'd0, reg_write_wb}, 128'd1);
            chk("perm_c4_data", rt_wb, VA5);
         end
         step();
      end
      chk("perm_c5_hit", {127'd0, fwd_hit_a}, 128'd0);

      // 4: same destination from both units, LS injected behind the permute result
      fwd_addr_b = 7'd9;
      perm_reg_write = 1'b1; perm_rt_addr = 7'd9; perm_rt = 128'd1;
      step(); idle();
      step(); step();
      chk("dup_c3_fwd_b", fwd_data_b, 128'd1);
      ls_reg_write_wb = 1'b1; ls_rt_addr_wb = 7'd9; ls_rt_wb = 128'd2;
      step(); idle();
      chk("dup_c4_fwd_b", fwd_data_b, 128'd2);
      chk("dup_c4_wb", rt_wb, 128'd1);
      chk("dup_c4_rw", {127'd0, reg_write_wb}, 128'd1);
      step();
      chk("dup_c5_wb", rt_wb, 128'd2);
      chk("dup_c5_rw", {127'd0, reg_write_wb}, 128'd1);
      chk("dup_slot_err", {127'd0, slot_err}, 128'd0);
      step();

      // 6: reset mid-flight discards the LocalStore result
      fwd_addr_a = 7'h11;
      ls_reg_write_wb = 1'b1; ls_rt_addr_wb = 7'h11; ls_rt_wb = 128'h33;
      step(); idle();
      chk("mid_c1_hit", {127'd0, fwd_hit_a}, 128'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid_c2_rw", {127'd0, reg_write_wb}, 128'd0);
      chk("mid_c2_hit", {125'd0, fwd_hit_a, fwd_hit_b, fwd_hit_c}, 128'd0);
      step();
      chk("mid_c3_rw", {127'd0, reg_write_wb}, 128'd0);

      // 5: LS lands on the slot the permute result is moving into
      fwd_addr_c = 7'd7;
      perm_reg_write = 1'b1; perm_rt_addr = 7'd7; perm_rt = 128'h77;
      step(); idle();
      step();
      chk("col_c2_err", {127'd0, slot_err}, 128'd0);
      ls_reg_write_wb = 1'b1; ls_rt_addr_wb = 7'd8; ls_rt_wb = 128'h88;
      step(); idle();
      chk("col_c3_err", {127'd0, slot_err}, 128'd1);
      chk("col_c3_hit_c", {127'd0, fwd_hit_c}, 128'd0);
      step();
      chk("col_c4_addr", {121'd0, rt_addr_wb}, 128'd8);
      chk("col_c4_data", rt_wb, 128'h88);
      step();
      chk("col_c5_rw", {127'd0, reg_write_wb}, 128'd0);
      chk("col_c5_err", {127'd0, slot_err}, 128'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("col_rst_err", {127'd0, slot_err}, 128'd0);

      // Mixed traffic over a few live addresses, checked by the model each cycle
      fwd_addr_a = 7'd0; fwd_addr_b = 7'd1; fwd_addr_c = 7'd2;
      for (int i = 0; i < 60; i++) begin
         perm_reg_write  = ($urandom_range(0, 2) == 0);
         perm_rt_addr    = 7'($urandom_range(0, 3));
         perm_rt         = {$urandom, $urandom, $urandom, $urandom};
         ls_reg_write_wb = ($urandom_range(0, 2) == 0);
         ls_rt_addr_wb   = 7'($urandom_range(0, 3));
         ls_rt_wb        = {$urandom, $urandom, $urandom, $urandom};
         if (i % 7 == 0) begin
            fwd_addr_a = 7'($urandom_range(0, 3));
         end
         step();
      end
      idle();
      repeat (DEPTH + 1) step();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
